core_bus_responder: RTL

CORE_BUS_RESPONDER -- requirements
Module: core_bus_responder

---
 rtl/core_bus_pkg.sv | 34 +++
 rtl/core_bus_responder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/core_bus_pkg.sv
// Bus payload types shared by the instruction and data ports of the core bus responder.
package core_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/core_bus_responder.sv
// Shared single-ported word RAM serving an instruction and a data port,
// one transaction in flight, fixed response latency.
module core_bus_responder
    import core_bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        last_d;
    logic        gnt_d;
    logic [31:0] buf_q;
    logic        i_dok;
    logic        d_dok;
    logic [31:0] i_data;
    logic [31:0] d_data;

    logic          grant_d_c;
    logic          accept_c;
    logic          wr_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   rd_word_c;
    logic          unused_c;

    logic [31:0] mem [MEM_WORDS];

    // Arbitration and acceptance; a tie goes to the port not granted last.
    always_comb begin
        grant_d_c = 1'b0;
        accept_c  = 1'b0;
        wr_c      = 1'b0;
        idx_c     = '0;
        rd_word_c = '0;
        grant_d_c = dreq.valid & (~ireq.valid | ~last_d);
        accept_c  = resetn & (state == IDLE) & (ireq.valid | dreq.valid);
        wr_c      = grant_d_c & (dreq.strobe != 4'b0000);
        idx_c     = grant_d_c ? dreq.addr[AW+1:2] : ireq.addr[AW+1:2];
        rd_word_c = wr_c ? 32'h0 : mem[idx_c];
    end

    assign unused_c = ^{ireq.addr[31:AW+2], ireq.addr[1:0],
                        dreq.addr[31:AW+2], dreq.addr[1:0], dreq.size};

    // Byte-lane write at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_c && wr_c) begin
            for (int b = 0; b < 4; b++) begin
                if (dreq.strobe[b]) begin
                    mem[idx_c][8*b +: 8] <= dreq.data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            last_d <= 1'b0;
            gnt_d  <= 1'b0;
            buf_q  <= 32'h0;
            i_dok  <= 1'b0;
            d_dok  <= 1'b0;
            i_data <= 32'h0;
            d_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        gnt_d  <= grant_d_c;
                        last_d <= grant_d_c;
                        buf_q  <= rd_word_c;
                        if (LATENCY <= 1) begin
                            state  <= RESP;
                            i_dok  <= ~grant_d_c;
                            d_dok  <= grant_d_c;
                            i_data <= grant_d_c ? 32'h0 : rd_word_c;
                            d_data <= grant_d_c ? rd_word_c : 32'h0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state  <= RESP;
                        cnt    <= 4'd0;
                        i_dok  <= ~gnt_d;
                        d_dok  <= gnt_d;
                        i_data <= gnt_d ? 32'h0 : buf_q;
                        d_data <= gnt_d ? buf_q : 32'h0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    i_dok  <= 1'b0;
                    d_dok  <= 1'b0;
                    i_data <= 32'h0;
                    d_data <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // addr_ok is combinational so a grant is visible in the IDLE cycle itself.
    always_comb begin
        iresp         = '0;
        dresp         = '0;
        iresp.addr_ok = accept_c & ~grant_d_c;
        iresp.data_ok = i_dok;
        iresp.data    = i_data;
        dresp.addr_ok = accept_c & grant_d_c;
        dresp.data_ok = d_dok;
        dresp.data    = d_data;
    end

endmodule
